// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host-side blocks: transmitter FSM states,
// frame geometry, the device ACK level, default cycle counts, and the parity
// helper used when a command byte is latched.
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_ABORT
  } ps2_tx_state_e;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  // Level the device drives on the data line to acknowledge a frame.
  localparam logic ACK_LEVEL = 1'b0;

  // Defaults assume a 100 MHz system clock.
  localparam int DEF_INHIBIT_CYCLES     = 10000;    // 100 us
  localparam int DEF_REQ_TIMEOUT_CYCLES = 1500000;  // 15 ms
  localparam int DEF_PKT_TIMEOUT_CYCLES = 200000;   // 2 ms
  localparam int DEF_FILTER_CYCLES      = 8;

  // Timeout counters; wide enough for the 15 ms default without wrapping.
  localparam int TIMER_W = 32;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
// Conditions one raw PS/2 line: 2-flop synchronizer, then a stability filter
// that accepts a new level only after FILTER_CYCLES consecutive samples
// disagree with the current filtered level, then a falling-edge pulse.
//
// Ports
//   clk_100mHz  system clock
//   reset       asynchronous active-high reset (line treated as idle-high)
//   line_i      raw pin level
//   level_o     filtered line level
//   fall_o      one-cycle pulse when level_o goes 1 -> 0
// ---------------------------------------------------------------------------
module ps2_line_filter #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk_100mHz,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  localparam int CW = ($clog2(FILTER_CYCLES) < 1) ? 1 : $clog2(FILTER_CYCLES);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic          fall_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values; blocking here would collapse the
  // synchronizer into a single stage.
  always_ff @(posedge clk_100mHz or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        // Any agreeing sample restarts the run, so short glitches vanish.
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
        fall_q  <= level_q;  // old level 1 means this is a falling edge
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Inhibits the clock, requests to send,
// then shifts one command byte out on device-generated falling clock edges
// and reports the device ACK/NACK or a timeout. Pins are driven
// open-collector: an oe of 1 pulls the line low, 0 releases it.
//
// Ports
//   clk_100mHz   system clock
//   reset        asynchronous active-high reset, releases both lines
//   tx_data      byte to send, latched on an accepted tx_start
//   tx_start     one-cycle request, honoured only when idle
//   ps2_clk_in   raw ps2_clk pin level
//   ps2_data_in  raw ps2_data pin level
//   ps2_clk_oe   1 = drive ps2_clk low
//   ps2_data_oe  1 = drive ps2_data low
//   busy         high whenever a transaction is in progress
//   tx_done      one-cycle pulse at the end of every transaction
//   tx_error     NACK or timeout; valid with tx_done, held until next start
// ---------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES     = DEF_INHIBIT_CYCLES,
  parameter int REQ_TIMEOUT_CYCLES = DEF_REQ_TIMEOUT_CYCLES,
  parameter int PKT_TIMEOUT_CYCLES = DEF_PKT_TIMEOUT_CYCLES,
  parameter int FILTER_CYCLES      = DEF_FILTER_CYCLES
) (
  input  logic       clk_100mHz,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  logic clk_level;
  logic clk_fall;
  logic data_level;
  logic unused_data_fall;  // data edges carry no meaning on the send side

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
    .clk_100mHz (clk_100mHz),
    .reset      (reset),
    .line_i     (ps2_clk_in),
    .level_o    (clk_level),
    .fall_o     (clk_fall)
  );

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
    .clk_100mHz (clk_100mHz),
    .reset      (reset),
    .line_i     (ps2_data_in),
    .level_o    (data_level),
    .fall_o     (unused_data_fall)
  );

  ps2_tx_state_e      state_q;
  logic [9:0]         frame_q;    // {stop, parity, d7..d0}, LSB goes out next
  logic [3:0]         bit_cnt_q;  // falling edges consumed in this frame
  logic [TIMER_W-1:0] timer_q;    // inhibit length, then request timeout
  logic [TIMER_W-1:0] pkt_q;      // time since the first device edge
  logic               clk_oe_q;
  logic               data_oe_q;
  logic               busy_q;
  logic               done_q;
  logic               error_q;

  always_ff @(posedge clk_100mHz or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      timer_q   <= '0;
      pkt_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tx_start) begin
            frame_q   <= {1'b1, odd_parity(tx_data), tx_data};
            bit_cnt_q <= '0;
            timer_q   <= '0;
            error_q   <= 1'b0;
            clk_oe_q  <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          timer_q <= timer_q + 1'b1;
          // Data goes low one cycle before the clock is released so the
          // device sees the start bit already present at release.
          if (timer_q == TIMER_W'(INHIBIT_CYCLES - 2)) begin
            data_oe_q <= 1'b1;
          end
          if (timer_q == TIMER_W'(INHIBIT_CYCLES - 1)) begin
            clk_oe_q <= 1'b0;
            timer_q  <= '0;
            state_q  <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (clk_fall) begin
            // First device edge clocks in the start bit; present d0 now.
            data_oe_q <= ~frame_q[0];
            frame_q   <= frame_q >> 1;
            bit_cnt_q <= 4'd1;
            pkt_q     <= '0;
            state_q   <= ST_SEND;
          end else if (timer_q == TIMER_W'(REQ_TIMEOUT_CYCLES - 1)) begin
            data_oe_q <= 1'b0;
            state_q   <= ST_ABORT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        ST_SEND: begin
          pkt_q <= pkt_q + 1'b1;
          if (pkt_q == TIMER_W'(PKT_TIMEOUT_CYCLES - 1)) begin
            data_oe_q <= 1'b0;
            state_q   <= ST_ABORT;
          end else if (clk_fall) begin
            // Edges 2..9 present d1..d7 and parity; edge 10 releases (stop).
            data_oe_q <= ~frame_q[0];
            frame_q   <= frame_q >> 1;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 4'(FRAME_BITS - 2)) begin
              state_q <= ST_ACK;
            end
          end
        end

        ST_ACK: begin
          pkt_q <= pkt_q + 1'b1;
          if (pkt_q == TIMER_W'(PKT_TIMEOUT_CYCLES - 1)) begin
            data_oe_q <= 1'b0;
            state_q   <= ST_ABORT;
          end else if (clk_fall) begin
            error_q   <= (data_level != ACK_LEVEL);
            bit_cnt_q <= bit_cnt_q + 1'b1;
            state_q   <= ST_WAIT_IDLE;
          end
        end

        ST_WAIT_IDLE: begin
          if (clk_level && data_level) begin
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            bit_cnt_q <= '0;
            state_q   <= ST_IDLE;
          end
        end

        ST_ABORT: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          error_q   <= 1'b1;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          bit_cnt_q <= '0;
          state_q   <= ST_IDLE;
        end

        default: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Directed bench for ps2_host_tx with a simple PS/2 device model that clocks
// frames, reads back the data line and ACKs or NACKs.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INHIBIT = 10000;
  localparam int REQ_TO  = 3000;
  localparam int PKT_TO  = 5000;
  localparam int FILT    = 8;
  localparam int HALF    = 40;  // device clock half period in system cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  int checks = 0;
  int failures = 0;

  // Open-collector bus with pull-ups: either side can pull a line low.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES     (INHIBIT),
    .REQ_TIMEOUT_CYCLES (REQ_TO),
    .PKT_TIMEOUT_CYCLES (PKT_TO),
    .FILTER_CYCLES      (FILT)
  ) dut (
    .clk_100mHz  (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error)
  );

  always #5 clk = ~clk;

  // Timestamps (in falling-edge counts) of output transitions.
  int   cyc = 0;
  int   clk_rise_cyc = 0;
  int   clk_fall_cyc = 0;
  int   data_rise_cyc = 0;
  int   done_cyc = 0;
  int   done_count = 0;
  logic clk_oe_prev = 1'b0;
  logic data_oe_prev = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ps2_clk_oe && !clk_oe_prev) clk_rise_cyc <= cyc;
    if (!ps2_clk_oe && clk_oe_prev) clk_fall_cyc <= cyc;
    if (ps2_data_oe && !data_oe_prev) data_rise_cyc <= cyc;
    if (tx_done) begin
      done_cyc   <= cyc;
      done_count <= done_count + 1;
    end
    clk_oe_prev  <= ps2_clk_oe;
    data_oe_prev <= ps2_data_oe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_tx(input logic [7:0] b);
    check("clk_oe_before_start", 32'(ps2_clk_oe), 32'd0);
    tx_data  = b;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    check("clk_oe_cycle_after_start", 32'(ps2_clk_oe), 32'd1);
    check("busy_after_start", 32'(busy), 32'd1);
    check("tx_error_cleared_on_start", 32'(tx_error), 32'd0);
  endtask

  // Waits for the clock inhibit to end and checks its timing.
  task automatic wait_release();
    bit seen = 1'b0;
    for (int i = 0; i < INHIBIT + 100; i++) begin
      if (!ps2_clk_oe) begin
        seen = 1'b1;
        break;
      end
      tick(1);
    end
    check("clk_released", 32'(seen), 32'd1);
    tick(1);
    check("inhibit_length", 32'(clk_fall_cyc - clk_rise_cyc), 32'(INHIBIT));
    check("data_oe_lead", 32'(clk_fall_cyc - data_rise_cyc), 32'd1);
    check("start_bit_driven", 32'(ps2_data_oe), 32'd1);
  endtask

  // Device model: 11 falling edges, data sampled late in each low phase.
  // seen[0] is the line before edge 1, seen[k] the bit presented after edge k.
  task automatic run_frame(input bit ack, input int glitch_at, input int inject_at,
                           input int reset_at, output logic [10:0] seen);
    seen = '0;
    tick(HALF);
    seen[0] = ps2_data_in;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) dev_data_low = ack;
      if (k == glitch_at) begin
        tick(10);
        dev_clk_low = 1'b1;
        tick(5);
        dev_clk_low = 1'b0;
        tick(HALF - 15);
      end else begin
        tick(HALF);
      end
      dev_clk_low = 1'b1;
      if (k == inject_at) begin
        tick(2);
        check("busy_during_send", 32'(busy), 32'd1);
        tx_data  = 8'hAA;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        tick(HALF - 3);
      end else if (k == reset_at) begin
        tick(HALF / 2);
        #1 reset = 1'b1;
        #1;
        check("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("reset_data_oe", 32'(ps2_data_oe), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        tick(1);
        reset = 1'b0;
        return;
      end else begin
        tick(HALF);
      end
      if (k <= 10) seen[k] = ps2_data_in;
      dev_clk_low = 1'b0;
    end
    tick(5);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input logic exp_err, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (tx_done) begin
        got = 1'b1;
        break;
      end
      tick(1);
    end
    check("tx_done_seen", 32'(got), 32'd1);
    if (got) begin
      check("busy_low_with_done", 32'(busy), 32'd0);
      check("tx_error_with_done", 32'(tx_error), 32'(exp_err));
      check("lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
      tick(1);
      check("tx_done_one_cycle", 32'(tx_done), 32'd0);
      check("tx_error_held", 32'(tx_error), 32'(exp_err));
    end
  endtask

  logic [10:0] frame;
  int          dc;

  initial begin
    // Reset state
    tick(3);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_tx_error", 32'(tx_error), 32'd0);
    reset = 1'b0;
    tick(5);

    // 0xF4 with ACK; a 0xAA request during SEND must be ignored.
    // Expected {stop=1, parity=0, F4, start=0}.
    start_tx(8'hF4);
    wait_release();
    run_frame(1'b1, 0, 3, 0, frame);
    check("frame_f4", 32'(frame), 32'(11'b1_0_11110100_0));
    wait_done(1'b0, 500);
    tick(20);
    check("no_queued_start", 32'(busy), 32'd0);

    // 0xFF with ACK and a 5-cycle clock glitch before edge 4.
    // Expected {1, parity=1, FF, 0}.
    start_tx(8'hFF);
    wait_release();
    run_frame(1'b1, 4, 0, 0, frame);
    check("frame_ff", 32'(frame), 32'(11'b1_1_11111111_0));
    check("parity_ff_released", 32'(frame[9]), 32'd1);
    wait_done(1'b0, 500);
    tick(20);

    // 0x00 with ACK. Expected {1, parity=1, 00, 0}.
    start_tx(8'h00);
    wait_release();
    run_frame(1'b1, 0, 0, 0, frame);
    check("frame_00", 32'(frame), 32'(11'b1_1_00000000_0));
    wait_done(1'b0, 500);
    tick(20);

    // 0xED, device NACKs (data left high at edge 11). Expected {1, 1, ED, 0}.
    start_tx(8'hED);
    wait_release();
    run_frame(1'b0, 0, 0, 0, frame);
    check("frame_ed", 32'(frame), 32'(11'b1_1_11101101_0));
    wait_done(1'b1, 500);
    tick(20);

    // No device clock: request timeout.
    start_tx(8'hF4);
    wait_release();
    wait_done(1'b1, REQ_TO + 200);
    tick(1);
    check("req_timeout_window",
          32'((done_cyc - clk_fall_cyc >= REQ_TO) && (done_cyc - clk_fall_cyc <= REQ_TO + 2)),
          32'd1);
    tick(20);

    // Reset while d4 is on the line: no tx_done afterwards.
    start_tx(8'hF4);
    wait_release();
    dc = done_count;
    run_frame(1'b1, 0, 0, 5, frame);
    tick(200);
    check("no_done_after_reset", 32'(done_count - dc), 32'd0);
    check("idle_after_reset", 32'({busy, ps2_clk_oe, ps2_data_oe}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: the send side of the PS/2 link whose receive side is the existing `Ps2Interface` (`rx_data`/`read_data`). It sends one command byte to the attached keyboard or mouse, for example 0xF4 enable-reporting or 0xFF reset. It sits beside `Ps2Interface` on the same `ps2_clk`/`ps2_data` inout pins and drives them open-collector via output enables. It reports completion, and it reports device ACK or NACK/timeout.

## Interface
- `INHIBIT_CYCLES`, default 10000 — clock-low inhibit time (100 µs at 100 MHz).
- `REQ_TIMEOUT_CYCLES`, default 1500000 — maximum wait from clock release to first device falling edge (15 ms).
- `PKT_TIMEOUT_CYCLES`, default 200000 — maximum time from first falling edge to ACK edge (2 ms).
- `FILTER_CYCLES`, default 8 — consecutive stable samples required before a synchronized line level is accepted.
- `clk_100mHz  in  1` — sole clock; all logic on its rising edge.
- `reset  in  1` — asynchronous, active-high; forces IDLE and releases both lines.
- `tx_data  in  8` — byte to send; captured on an accepted `tx_start`.
- `tx_start  in  1` — one-cycle request; accepted only in IDLE.
- `ps2_clk_in  in  1` — raw level of the `ps2_clk` pin.
- `ps2_data_in  in  1` — raw level of the `ps2_data` pin.
- `ps2_clk_oe  out  1` — 1 = drive `ps2_clk` low, 0 = release (pad ties to 1'bz).
- `ps2_data_oe  out  1` — 1 = drive `ps2_data` low, 0 = release.
- `busy  out  1` — high in every state except IDLE.
- `tx_done  out  1` — one-cycle pulse at the end of every transaction, success or failure.
- `tx_error  out  1` — valid with `tx_done`; held until the next accepted `tx_start`.

## Operation
- Reset values: `ps2_clk_oe`=0, `ps2_data_oe`=0, `busy`=0, `tx_done`=0, `tx_error`=0, state IDLE, bit counter 0.
- Frame is 11 bits: start(0), d0..d7 LSB first, odd parity, stop(1), then a device ACK(0).
- Parity equals `~^tx_data`.
- IDLE: on `tx_start`, latch `tx_data` and the parity bit, clear `tx_error`, go to INHIBIT.
- INHIBIT: `ps2_clk_oe`=1 for INHIBIT_CYCLES cycles. `ps2_data_oe` goes to 1 in the final inhibit cycle. Then go to REQ.
- REQ: `ps2_clk_oe`=0, `ps2_data_oe`=1 (start bit). Wait for a filtered falling edge of the clock.
  - Edge arrives: go to SEND.
  - REQ_TIMEOUT_CYCLES elapse first: go to ABORT.
- SEND, entered with bit index 0. At each filtered falling edge, `ps2_data_oe` takes the next bit, where a 1-bit means release (oe=0) and a 0-bit means drive (oe=1):
  - edges 1–8: d0..d7;
  - edge 9: parity;
  - edge 10: release (stop).
  - After edge 10, go to ACK.
- ACK: at the next falling edge, sample the filtered data line. `tx_error` = sampled level (0 = ACK). Go to WAIT_IDLE.
- WAIT_IDLE: wait until both filtered lines are high, then pulse `tx_done` and go to IDLE.
- PKT timer runs from the first edge seen in REQ. If it expires in SEND or ACK, go to ABORT.
- ABORT: release both lines, set `tx_error`=1, pulse `tx_done`, go to IDLE.
- `tx_start` while `busy` is ignored; it is neither queued nor allowed to change the latched byte.
- Reset mid-transaction: both oe outputs drop asynchronously and no `tx_done` is issued.

## Timing
- Line path: 2-flop synchronizer, then a FILTER_CYCLES stability filter, then fall-edge detect. Edge-to-action latency is 2+FILTER_CYCLES+1 cycles, well inside the ≥30 µs device clock-low phase.
- `ps2_clk_oe` rises the cycle after `tx_start` is sampled.
- `ps2_clk_oe` falls INHIBIT_CYCLES cycles later, one cycle after `ps2_data_oe` rises.
- `ps2_data_oe` changes only while the device clock is low, never on a rising edge.
- `tx_done` is exactly one cycle. `busy` falls in the same cycle `tx_done` is high.
- A glitch shorter than FILTER_CYCLES on either line produces no edge.
- Timeouts are counted in cycles using ≥21-bit counters; no wrap is permitted before terminal count.

## Structure
- Shared package `ps2_pkg` holds:
  - the state enum (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, ABORT);
  - the frame-length constant (11);
  - the ACK level constant;
  - the default cycle counts.
- Sub-module `ps2_line_filter` (synchronizer, stability filter, filtered level, fall-edge pulse) is instantiated twice, once per line. It is also reusable by `Ps2Interface`.

## Test plan
- `tx_start` with 0xF4, device model ACKs → edges 1–9 present data 0,0,1,0,1,1,1,1 then parity 0; `tx_done` pulses with `tx_error`=0.
- 0xFF with ACK → parity bit 1 (oe=0 at edge 9); 0x00 → parity bit 1; both end with `tx_error`=0.
- Device holds data high at edge 11 (NACK) → `tx_done` with `tx_error`=1, lines released.
- No device clock after request → ABORT after REQ_TIMEOUT_CYCLES; `tx_error`=1 and oe=0,0; clock inhibit measured at exactly 10000 cycles.
- Second `tx_start` with 0xAA during SEND → ignored, 0xF4 frame unchanged. Reset asserted at bit 4 → oe=0,0 immediately, `busy`=0, no `tx_done`.
- 5-cycle low glitch on `ps2_clk_in` during SEND → bit index unchanged, frame still correct.
